// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared ALU opcode, flag and control-state types for the multicycle ALU.
// Rev 1.0
`default_nettype none

package alu_mc_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SRA = 3'd7
  } alu_opcode_t;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } alu_flags_t;

  typedef enum logic [1:0] {
    ALU_IDLE  = 2'd0,
    ALU_EXEC  = 2'd1,
    ALU_SHIFT = 2'd2,
    ALU_DONE  = 2'd3
  } alu_state_t;

  function automatic logic is_shift(input alu_opcode_t op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mc_shift_step.sv
// alu_mc_shift_step: combinational one-bit SLL/SRL/SRA step, also returning the bit shifted out.
// Rev 1.0
`default_nettype none

module alu_mc_shift_step
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data_i,
  input  alu_opcode_t      op_i,
  output logic [WIDTH-1:0] data_o,
  output logic             out_bit_o
);

  always_comb begin
    data_o    = data_i;
    out_bit_o = 1'b0;
    case (op_i)
      ALU_SLL: begin
        data_o    = {data_i[WIDTH-2:0], 1'b0};
        out_bit_o = data_i[WIDTH-1];
      end
      ALU_SRL: begin
        data_o    = {1'b0, data_i[WIDTH-1:1]};
        out_bit_o = data_i[0];
      end
      ALU_SRA: begin
        data_o    = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
        out_bit_o = data_i[0];
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_mc.sv
// alu_mc: multicycle WIDTH-bit ALU with start/busy/done handshake and a flag register.
// Rev 1.0 -- ALU_BARREL_SHIFT_EN selects a single-cycle barrel shifter instead of the iterative one.
`default_nettype none

module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  alu_opcode_t      op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flag_load_i,
  output logic [WIDTH-1:0] result_o,
  output alu_flags_t       flags_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_t       state_q;
  alu_opcode_t      op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             flag_load_q;
  logic [WIDTH-1:0] result_q;
  alu_flags_t       flags_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] exec_res_d;
  alu_flags_t       exec_flags_d;
  logic [WIDTH:0]   sum_d;

`ifdef ALU_BARREL_SHIFT_EN
  // Extra bit beside the data catches the last bit shifted out.
  logic [WIDTH:0]   wide_d;
`else
  logic [SHW-1:0]   cnt_q;
  logic             sout_q;
  logic [WIDTH-1:0] step_data;
  logic             step_bit;

  alu_mc_shift_step #(.WIDTH(WIDTH)) u_shift_step (
    .data_i    (a_q),
    .op_i      (op_q),
    .data_o    (step_data),
    .out_bit_o (step_bit)
  );
`endif

  always_comb begin
    exec_res_d   = a_q;
    exec_flags_d = '0;
    sum_d        = '0;
`ifdef ALU_BARREL_SHIFT_EN
    wide_d       = '0;
`endif
    case (op_q)
      ALU_ADD: begin
        sum_d                 = {1'b0, a_q} + {1'b0, b_q};
        exec_res_d            = sum_d[WIDTH-1:0];
        exec_flags_d.carry    = sum_d[WIDTH];
        exec_flags_d.overflow = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
      end
      ALU_SUB: begin
        sum_d                 = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
        exec_res_d            = sum_d[WIDTH-1:0];
        exec_flags_d.carry    = sum_d[WIDTH];
        exec_flags_d.overflow = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
      end
      ALU_AND: exec_res_d = a_q & b_q;
      ALU_OR:  exec_res_d = a_q | b_q;
      ALU_XOR: exec_res_d = a_q ^ b_q;
`ifdef ALU_BARREL_SHIFT_EN
      ALU_SLL: begin
        wide_d             = {1'b0, a_q} << b_q[SHW-1:0];
        exec_res_d         = wide_d[WIDTH-1:0];
        exec_flags_d.carry = wide_d[WIDTH];
      end
      ALU_SRL: begin
        wide_d             = {a_q, 1'b0} >> b_q[SHW-1:0];
        exec_res_d         = wide_d[WIDTH:1];
        exec_flags_d.carry = wide_d[0];
      end
      ALU_SRA: begin
        wide_d             = $signed({a_q, 1'b0}) >>> b_q[SHW-1:0];
        exec_res_d         = wide_d[WIDTH:1];
        exec_flags_d.carry = wide_d[0];
      end
`endif
      default: ;
    endcase
    exec_flags_d.zero     = (exec_res_d == '0);
    exec_flags_d.negative = exec_res_d[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ALU_IDLE;
      op_q        <= ALU_ADD;
      a_q         <= '0;
      b_q         <= '0;
      flag_load_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      cnt_q       <= '0;
      sout_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ALU_IDLE: begin
          if (start_i) begin
            op_q        <= op_i;
            a_q         <= a_i;
            b_q         <= b_i;
            flag_load_q <= flag_load_i;
            busy_q      <= 1'b1;
`ifdef ALU_BARREL_SHIFT_EN
            state_q     <= ALU_EXEC;
`else
            cnt_q       <= b_i[SHW-1:0];
            sout_q      <= 1'b0;
            state_q     <= is_shift(op_i) ? ALU_SHIFT : ALU_EXEC;
`endif
          end
        end
        ALU_EXEC: begin
          result_q <= exec_res_d;
          if (flag_load_q) flags_q <= exec_flags_d;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= ALU_DONE;
        end
`ifndef ALU_BARREL_SHIFT_EN
        ALU_SHIFT: begin
          // a_q doubles as the shift register; finish one cycle after the count runs out.
          if (cnt_q == '0) begin
            result_q <= a_q;
            if (flag_load_q) begin
              flags_q <= '{zero: (a_q == '0), negative: a_q[WIDTH-1], carry: sout_q, overflow: 1'b0};
            end
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ALU_DONE;
          end else begin
            a_q    <= step_data;
            sout_q <= step_bit;
            cnt_q  <= cnt_q - SHW'(1);
          end
        end
`endif
        ALU_DONE: state_q <= ALU_IDLE;
        default:  state_q <= ALU_IDLE;
      endcase
    end
  end

  assign result_o = result_q;
  assign flags_o  = flags_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

`default_nettype wire
